// File: rtl/seg7_scan_display_pkg.sv
// Shared seven-segment definitions: blank pattern, active-low hex glyphs and
// the width helper for the refresh prescaler.
package seg7_scan_display_pkg;

  typedef logic [3:0] nibble_t;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Scan ring states; the state value doubles as the digit index
  localparam logic [1:0] DIG0 = 2'd0;
  localparam logic [1:0] DIG1 = 2'd1;
  localparam logic [1:0] DIG2 = 2'd2;
  localparam logic [1:0] DIG3 = 2'd3;

  // Bits needed to count 0..value-1, never less than one
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph decoder, shared by
// the display blocks.
module hex_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit history of captured nibbles, time-multiplexed onto a
// common-anode seven-segment display with registered, glitch-free outputs.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din_valid,
  input  logic [3:0] din,
  input  logic       hold,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       scan_tick
);

  localparam int CNT_W = clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             slot_end;
  logic [1:0]       scan_idx;
  logic [1:0]       scan_next;
  nibble_t          digit [4];
  logic [3:0]       fill;
  logic [6:0]       glyph;
  logic             capture;

  assign slot_end = (cnt == CNT_LAST);
  assign capture  = din_valid && !hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    scan_next = DIG0;
    case (scan_idx)
      DIG0:    scan_next = DIG1;
      DIG1:    scan_next = DIG2;
      DIG2:    scan_next = DIG3;
      DIG3:    scan_next = DIG0;
      default: scan_next = DIG0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_idx <= DIG0;
    end else if (slot_end) begin
      scan_idx <= scan_next;
    end
  end

  // Newest nibble enters at digit 0; fill marks which slots hold real data
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) digit[i] <= '0;
      fill <= '0;
    end else if (capture) begin
      digit[3] <= digit[2];
      digit[2] <= digit[1];
      digit[1] <= digit[0];
      digit[0] <= din;
      fill     <= {fill[2:0], 1'b1};
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (digit[scan_idx]),
    .seg    (glyph)
  );

  // Output stage: an and seg update on the same edge from last cycle's state
  always_ff @(posedge clk) begin
    if (!reset) begin
      an        <= 4'b1111;
      seg       <= SEG_BLANK;
      scan_tick <= 1'b0;
    end else begin
      an        <= ~(4'b0001 << scan_idx);
      seg       <= fill[scan_idx] ? glyph : SEG_BLANK;
      scan_tick <= slot_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: two instances (REFRESH_DIV 4 and 1)
// share stimulus; a behavioural model feeds an expected-output queue each edge.
module tb_seg7_scan_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       din_valid;
  logic [3:0] din;
  logic       hold;
  logic [3:0] an4, an1;
  logic [6:0] seg4, seg1;
  logic       tick4, tick1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    int         cnt;
    int         idx;
    logic [15:0] dig;
    logic [3:0] fill;
    logic [3:0] an;
    logic [6:0] seg;
    logic       tick;
  } model_t;

  typedef struct packed {
    logic [3:0] an4;
    logic [6:0] seg4;
    logic       tick4;
    logic [3:0] an1;
    logic [6:0] seg1;
    logic       tick1;
  } exp_t;

  model_t m4, m1;
  exp_t   sb [$];

  always #5 clk = ~clk;

  seg7_scan_display #(.REFRESH_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .hold(hold),
    .an(an4), .seg(seg4), .scan_tick(tick4)
  );

  seg7_scan_display #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .hold(hold),
    .an(an1), .seg(seg1), .scan_tick(tick1)
  );

  function automatic model_t mstep(model_t m, int div, logic rst_n, logic dv,
                                   logic hd, logic [3:0] d);
    model_t n;
    n = m;
    if (!rst_n) begin
      n.cnt = 0; n.idx = 0; n.dig = '0; n.fill = '0;
      n.an = 4'hF; n.seg = 7'h7F; n.tick = 1'b0;
      return n;
    end
    n.an   = ~(4'b0001 << m.idx);
    n.seg  = m.fill[m.idx] ? hex_tab[m.dig[4*m.idx +: 4]] : 7'h7F;
    n.tick = (m.cnt == div - 1);
    if (m.cnt == div - 1) begin
      n.cnt = 0;
      n.idx = (m.idx + 1) % 4;
    end else begin
      n.cnt = m.cnt + 1;
    end
    if (dv && !hd) begin
      n.dig  = {m.dig[11:0], d};
      n.fill = {m.fill[2:0], 1'b1};
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    m4 = mstep(m4, 4, reset, din_valid, hold, din);
    m1 = mstep(m1, 1, reset, din_valid, hold, din);
    e.an4 = m4.an; e.seg4 = m4.seg; e.tick4 = m4.tick;
    e.an1 = m1.an; e.seg1 = m1.seg; e.tick1 = m1.tick;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk("sb_an4",   {3'b0, an4},   {3'b0, e.an4});
    chk("sb_seg4",  seg4,          e.seg4);
    chk("sb_tick4", {6'b0, tick4}, {6'b0, e.tick4});
    chk("sb_an1",   {3'b0, an1},   {3'b0, e.an1});
    chk("sb_seg1",  seg1,          e.seg1);
    chk("sb_tick1", {6'b0, tick1}, {6'b0, e.tick1});
  endtask

  // Advance at least one cycle, then until dut4 lights digit a; check its glyph
  task automatic expect_at(input string tag, input logic [3:0] a, input logic [6:0] s);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (an4 !== a && k < 40);
    chk({tag, "_an"}, {3'b0, an4}, {3'b0, a});
    chk(tag, seg4, s);
  endtask

  initial begin
    int ticks;
    int lit;
    int k;

    // Reset held with a pending capture
    reset = 1'b0; din_valid = 1'b1; din = 4'h5; hold = 1'b0;
    repeat (3) cyc();
    chk("rst_an", {3'b0, an4}, 7'h0F);
    chk("rst_seg", seg4, 7'h7F);

    // Free-running scan, no captures
    reset = 1'b1; din_valid = 1'b0;
    cyc();
    chk("rel_an", {3'b0, an4}, 7'h0E);
    chk("rel_seg", seg4, 7'h7F);
    ticks = 0;
    repeat (16) begin
      cyc();
      ticks += int'(tick4);
      chk("empty_seg", seg4, 7'h7F);
    end
    chk("tick_count", 7'(ticks), 7'd4);
    chk("wrap_an", {3'b0, an4}, 7'h0E);

    // Capture 1,2,3,4 back to back
    din_valid = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      din = 4'(v);
      cyc();
    end
    din_valid = 1'b0;
    expect_at("d0_4", 4'b1110, 7'h19);
    expect_at("d1_3", 4'b1101, 7'h30);
    expect_at("d2_2", 4'b1011, 7'h24);
    expect_at("d3_1", 4'b0111, 7'h79);

    // Push F, oldest digit drops out
    din_valid = 1'b1; din = 4'hF;
    cyc();
    din_valid = 1'b0;
    expect_at("f_d0", 4'b1110, 7'h0E);
    expect_at("f_d3", 4'b0111, 7'h24);

    // Hold ignores captures while scanning continues
    hold = 1'b1; din_valid = 1'b1; din = 4'h0;
    repeat (8) cyc();
    expect_at("hold_d0", 4'b1110, 7'h0E);
    expect_at("hold_d1", 4'b1101, 7'h19);
    hold = 1'b0; din_valid = 1'b0;

    // Mid-slot reset wipes history
    k = 0;
    while (!(m4.cnt == 2 && m4.idx == 2) && k < 40) begin
      cyc();
      k++;
    end
    chk("slot_found", 7'(m4.cnt * 4 + m4.idx), 7'd10);
    reset = 1'b0;
    cyc();
    chk("mid_rst_an", {3'b0, an4}, 7'h0F);
    chk("mid_rst_seg", seg4, 7'h7F);
    reset = 1'b1;
    cyc();
    chk("restart_an", {3'b0, an4}, 7'h0E);
    repeat (16) begin
      cyc();
      chk("wiped_seg", seg4, 7'h7F);
    end

    // REFRESH_DIV=1 instance: single captured 0 on the rightmost digit
    din_valid = 1'b1; din = 4'h0;
    cyc();
    din_valid = 1'b0;
    lit = 0;
    repeat (8) begin
      cyc();
      if (seg1 === 7'h40) begin
        lit++;
        chk("lit_an1", {3'b0, an1}, 7'h0E);
      end
    end
    chk("lit_count", 7'(lit), 7'd2);

    // Capture on the same edge as the 3->0 wrap
    k = 0;
    while (m1.idx != 3 && k < 8) begin
      cyc();
      k++;
    end
    din_valid = 1'b1; din = 4'h7;
    cyc();
    din_valid = 1'b0;
    cyc();
    chk("wrap_cap_an1", {3'b0, an1}, 7'h0E);
    chk("wrap_cap_seg1", seg1, 7'h78);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
